// File: rtl/aes_spi_loader.sv
// Serial loader for the AES core: shifts data/key frames in over mosi, latches
// complete frames and hands them to the core with a one-cycle start pulse.
module aes_spi_loader #(
  parameter int Nk = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs1,
  input  logic                cs2,
  input  logic                mosi,
  output logic                misod,
  output logic                misok,
  output logic [127:0]        data_out,
  output logic [32*Nk-1:0]    key_out,
  output logic                data_valid,
  output logic                key_valid,
  output logic                start,
  output logic                busy,
  input  logic                core_done,
  output logic                frame_err
);

  localparam int KEY_W = 32 * Nk;
  localparam logic [9:0] KEY_BITS = 10'(KEY_W);

  typedef enum logic [1:0] {IDLE, FIRE, RUN} state_t;

  state_t           state;
  logic [127:0]     data_sr;
  logic [KEY_W-1:0] key_sr;
  logic [7:0]       dcnt;
  logic [9:0]       kcnt;
  logic             cs1_d;
  logic             cs2_d;

  logic data_end;
  logic key_end;
  logic data_ok;
  logic key_ok;

  // A frame ends on the select's rising edge; it is kept only if long enough.
  assign data_end = cs1 & ~cs1_d;
  assign key_end  = cs2 & ~cs2_d;
  assign data_ok  = data_end && (dcnt >= 8'd128);
  assign key_ok   = key_end && (kcnt >= KEY_BITS);

  assign misod = data_sr[127];
  assign misok = key_sr[KEY_W-1];

  // Shifters, frame capture and the start/busy handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_sr    <= '0;
      key_sr     <= '0;
      dcnt       <= 8'd0;
      kcnt       <= 10'd0;
      cs1_d      <= 1'b1;
      cs2_d      <= 1'b1;
      data_out   <= '0;
      key_out    <= '0;
      data_valid <= 1'b0;
      key_valid  <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cs1_d <= cs1;
      cs2_d <= cs2;

      // Both selects low is a bus conflict: nothing shifts and both frames restart.
      if (!cs1 && !cs2) begin
        frame_err <= 1'b1;
        dcnt      <= 8'd0;
        kcnt      <= 10'd0;
      end else begin
        if (!cs1) begin
          data_sr <= {data_sr[126:0], mosi};
          if (dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
        end else if (data_end) begin
          dcnt <= 8'd0;
        end
        if (!cs2) begin
          key_sr <= {key_sr[KEY_W-2:0], mosi};
          if (kcnt != 10'h3FF) kcnt <= kcnt + 10'd1;
        end else if (key_end) begin
          kcnt <= 10'd0;
        end
      end

      if ((data_end && !data_ok) || (key_end && !key_ok)) frame_err <= 1'b1;

      case (state)
        IDLE: begin
          start <= 1'b0;
          if (data_valid && key_valid) begin
            start <= 1'b1;
            busy  <= 1'b1;
            state <= FIRE;
          end
        end
        FIRE: begin
          start      <= 1'b0;
          data_valid <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          start <= 1'b0;
          if (core_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          start <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Captures come last so a block arriving during FIRE stays queued.
      if (data_ok) begin
        data_out   <= data_sr;
        data_valid <= 1'b1;
      end
      if (key_ok) begin
        key_out   <= key_sr;
        key_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/aes_spi_loader.md
Name: aes_spi_loader

Overview:
- Serial front end that sits directly upstream of the Aes core.
- Shifts a 128-bit data block (cs1 frame) and a 32*Nk-bit key (cs2 frame) in over a shared mosi line.
- Echoes displaced bits out on misod/misok, latches completed frames, and issues a one-cycle start handshake to the core.
- The key is retained across blocks; data is consumed once per start.

Parameters:
Nk, 8, key length in 32-bit words (4/6/8); KEY_W = 32*Nk is a derived localparam

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
cs1  input  1  data frame select, active-low
cs2  input  1  key frame select, active-low
mosi  input  1  serial input bit, sampled on posedge clk
misod  output  1  data shifter MSB (full-duplex echo)
misok  output  1  key shifter MSB (full-duplex echo)
data_out  output  128  latched data block, presented to core
key_out  output  KEY_W  latched key, presented to core
data_valid  output  1  data_out holds an unconsumed block
key_valid  output  1  key_out holds a key (sticky until rst)
start  output  1  one-cycle pulse; core samples data_out/key_out this cycle
busy  output  1  core run in progress (start issued, core_done not yet seen)
core_done  input  1  core completion pulse (doneenc or donedec)
frame_err  output  1  sticky error flag, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at posedge) forces the following:
  - all outputs 0, both shifters 0, bit counters 0, state IDLE.
  - cs1/cs2 delay registers to 1, so no capture fires on the first cycle after reset.
  - Reset mid-frame discards partial frames and mid-run drops busy.
- Data shift: when cs1=0 and cs2=1:
  - data_sr <= {data_sr[126:0], mosi}.
  - dcnt increments; 8-bit counter, saturates at 255.
  - misod = data_sr[127], combinational from the register.
- Key shift: when cs2=0 and cs1=1:
  - key_sr <= {key_sr[KEY_W-2:0], mosi}.
  - kcnt increments; 10-bit counter, saturates at 1023.
  - misok = key_sr[KEY_W-1].
- Both cs low in the same cycle: neither shifter moves, frame_err <= 1, and both counters are cleared.
- Frame end is the cs rising edge (cs=1, cs_d=0), evaluated in that cycle:
  - cs1 end, dcnt >= 128: data_out <= data_sr (last 128 bits received), data_valid <= 1. Extra leading bits (e.g. 129-bit frame) are silently dropped.
  - cs1 end, dcnt < 128: frame discarded, frame_err <= 1, data_out/data_valid unchanged.
  - cs2 end: same rule with KEY_W against kcnt, updating key_out and key_valid.
  - Counter clears to 0 at every frame end.
- FSM:
  - IDLE -> FIRE when data_valid & key_valid.
  - FIRE: start=1 for exactly one cycle; data_valid <= 0; busy <= 1; -> RUN.
  - RUN: wait for core_done=1, then busy <= 0 -> IDLE.
- start latency: earliest start is the cycle after the capture edge that makes both valids 1.
- Simultaneous capture and FIRE:
  - Data capture in the FIRE cycle wins: data_valid stays 1, the new block is queued, and start fires again after core_done.
  - Key capture during FIRE or RUN updates key_out at the end of that cycle. The core already sampled the old key at start.
- Frames may be received during RUN; one data block is buffered, and a newer one overwrites it.
- core_done outside RUN is ignored.
- core_done in the same cycle as FIRE is ignored; RUN waits for the next pulse.
- Shifters keep their contents after frame end, so echo of the next frame begins with the previous frame's bits.

Test Plan:
- Reset, then 128-bit cs1 frame 00112233445566778899aabbccddeeff followed by 256-bit cs2 frame 000102…1e1f (Nk=8) -> data_out/key_out match; start pulses exactly once, one cycle after cs2 rises; busy=1 until core_done; data_valid=0 after FIRE.
- 129-bit cs1 frame (leading extra 1) with the same data -> data_out = 00112233…eeff, frame_err=0.
- Echo: after the first data frame, send a second 128-bit frame of all-ones -> misod emits 00112233…eeff MSB-first during the second frame.
- Short frame: 100 bits on cs1 -> frame_err=1, data_valid stays 0, no start. Then rst -> frame_err=0.
- Key reuse: after run 1 completes, send only a new data frame ffeeddcc…00 -> start fires with key_out unchanged (000102…1f).
- Error and reset cases:
  - cs1 and cs2 both low for 3 cycles mid-frame -> frame_err=1, counters cleared, no capture.
  - rst asserted while busy -> all outputs 0 next cycle.
